vga_scan_out: RTL and testbench

Raster-side endpoint of the display path. It generates 640x480@60 VGA scan timing and drives `h_cnt`/`v_cnt` into the combinational display composer. It takes back the composer's `pixel_addr`/`notBlank`, issues the pixel-ROM read and emits 12-bit RGB with hsync/vsync, all delay-matched to the same pixel. It also produces a once-per-frame tick for game logic.

---
 rtl/vga_scan_out_if.sv | 45 ++++
 rtl/vga_scan_out.sv | 169 ++++++++++++++++
 tb/tb_vga_scan_out.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_out_if.sv
// vga_scan_out_if
// Connects the raster endpoint to the combinational display composer and
// to the pixel ROM.
//
// Timing contract (there is no valid/ready handshake; everything is
// implied by the raster position):
//   - h_cnt/v_cnt are held stable for one whole pixel period.
//   - The slave must present pixel_addr/notBlank for the held h_cnt/v_cnt
//     before the end of that period. The master samples them only at that
//     instant and ignores them at all other times.
//   - mem_data must reflect mem_addr one clk after mem_addr changes.
//     The master samples it one pixel period later.
//
// Signals:
//   h_cnt, v_cnt  master->slave  raster position (10 bits each)
//   pixel_addr    slave->master  ROM address for the current position (17 bits)
//   notBlank      slave->master  an object covers the current position
//   mem_addr      master->slave  registered ROM address (17 bits)
//   mem_data      slave->master  ROM read data {R,G,B} (12 bits)
interface vga_scan_out_if;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [16:0] pixel_addr;
  logic        notBlank;
  logic [16:0] mem_addr;
  logic [11:0] mem_data;

  modport master (
    output h_cnt,
    output v_cnt,
    output mem_addr,
    input  pixel_addr,
    input  notBlank,
    input  mem_data
  );

  modport slave (
    input  h_cnt,
    input  v_cnt,
    input  mem_addr,
    output pixel_addr,
    output notBlank,
    output mem_data
  );
endinterface

// File: rtl/vga_scan_out.sv
// vga_scan_out
// Raster-side endpoint of the display path. Generates VGA scan timing
// (640x480@60 by default), hands the raster position to the composer,
// registers the returned ROM address, and emits 12-bit RGB plus active-low
// syncs, all delayed by exactly two pixel periods so colour and sync
// describe the same pixel. Also emits a one-clk frame_tick per frame.
//
// Ports:
//   clk         system clock (pixel rate = clk / TICK_DIV)
//   rst         asynchronous, active-low reset
//   disp        composer/ROM interface (master side)
//   vga_r/g/b   4-bit colour outputs
//   hsync/vsync active-low sync outputs
//   frame_tick  one-clk pulse when the raster wraps to (0,0)
//
// Geometry parameters default to the standard 640x480@60 timing.
module vga_scan_out #(
  parameter int          TICK_DIV  = 4,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_scan_out_if.master        disp,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_tick
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int PHASE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PHASE_W-1:0] phase;
  logic               pix_tick;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        h_last;
  logic        v_last;

  // Stage-0 decodes of the current raster position.
  logic        vis0;
  logic        hs0;
  logic        vs0;

  // Stage-1 pipeline; sync flags are active-high internally.
  logic [16:0] mem_addr;
  logic        nb1;
  logic        vis1;
  logic        hs1;
  logic        vs1;

  logic [11:0] rgb_next;
  logic [11:0] rgb;

  // Pixel-rate enable.
  assign pix_tick = (phase == PHASE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (pix_tick) begin
      phase <= '0;
    end else begin
      phase <= phase + PHASE_W'(1);
    end
  end

  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  // Raster counters. v_cnt only moves on an h_cnt wrap, so the
  // (last,last) -> (0,0) step happens in one tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    vis0 = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    hs0  = (h_cnt >= 10'(HS_START)) && (h_cnt <= 10'(HS_END));
    vs0  = (v_cnt >= 10'(VS_START)) && (v_cnt <= 10'(VS_END));
  end

  // Stage 1: the composer has had the whole pixel period to settle on the
  // held position, so its outputs are captured together with the decodes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
      nb1      <= 1'b0;
      vis1     <= 1'b0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
    end else if (pix_tick) begin
      mem_addr <= disp.pixel_addr;
      nb1      <= disp.notBlank;
      vis1     <= vis0;
      hs1      <= hs0;
      vs1      <= vs0;
    end
  end

  // Blanking outside the visible area overrides whatever the composer says.
  always_comb begin
    rgb_next = 12'h000;
    if (vis1) begin
      rgb_next = nb1 ? disp.mem_data : BG_COLOR;
    end
  end

  // Stage 2: mem_data has been valid since one clk after mem_addr moved,
  // i.e. TICK_DIV-1 clk of margin at this capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb   <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_tick) begin
      rgb   <= rgb_next;
      hsync <= ~hs1;
      vsync <= ~vs1;
    end
  end

  // High for the single clk following the edge that wraps the raster to (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_tick && h_last && v_last;
    end
  end

  assign vga_r         = rgb[11:8];
  assign vga_g         = rgb[7:4];
  assign vga_b         = rgb[3:0];
  assign disp.h_cnt    = h_cnt;
  assign disp.v_cnt    = v_cnt;
  assign disp.mem_addr = mem_addr;

endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out
// Two instances share one clock: dut_a uses the full 640x480 geometry
// (reset, line timing, data path); dut_b uses a small geometry so whole
// frames, vsync and mid-frame reset fit in a short run. A behavioural model
// derives every output from the number of clk edges since reset release.
module tb_vga_scan_out;

  localparam int          TD    = 4;
  localparam int          LIMIT = 20000;
  localparam logic [11:0] A_BG  = 12'hC3C;
  localparam logic [11:0] B_BG  = 12'h3A5;

  typedef struct {
    int          h_total;
    int          v_total;
    int          h_vis;
    int          v_vis;
    int          hs_lo;
    int          hs_hi;
    int          vs_lo;
    int          vs_hi;
    int          td;
    logic [11:0] bg;
    bit          rom_const;
  } geom_t;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [16:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        ft;
  } exp_t;

  geom_t ga = '{h_total:800, v_total:525, h_vis:640, v_vis:480, hs_lo:656, hs_hi:751,
                vs_lo:490, vs_hi:491, td:TD, bg:A_BG, rom_const:1'b0};
  geom_t gb = '{h_total:60, v_total:13, h_vis:40, v_vis:6, hs_lo:44, hs_hi:51,
                vs_lo:8, vs_hi:9, td:TD, bg:B_BG, rom_const:1'b1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int e_a      = 0;
  int e_b      = 0;
  int vmax_b   = 0;

  vga_scan_out_if if_a();
  vga_scan_out_if if_b();

  logic [3:0] ra, ga_o, ba, rb, gb_o, bb;
  logic       hs_a, vs_a, ft_a, hs_b, vs_b, ft_b;

  vga_scan_out #(.TICK_DIV(TD), .BG_COLOR(A_BG)) dut_a (
    .clk(clk), .rst(rst_a), .disp(if_a),
    .vga_r(ra), .vga_g(ga_o), .vga_b(ba),
    .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
  );

  vga_scan_out #(.TICK_DIV(TD), .BG_COLOR(B_BG),
                 .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(8),
                 .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_b (
    .clk(clk), .rst(rst_b), .disp(if_b),
    .vga_r(rb), .vga_g(gb_o), .vga_b(bb),
    .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
  );

  // Composer and ROM models.
  assign if_a.pixel_addr = 17'(32'(if_a.h_cnt) + 32'd640 * 32'(if_a.v_cnt));
  assign if_b.pixel_addr = 17'(32'(if_b.h_cnt) + 32'd640 * 32'(if_b.v_cnt));
  assign if_a.notBlank   = (if_a.h_cnt[3:0] != 4'd7);
  assign if_b.notBlank   = (if_b.h_cnt[3:0] != 4'd7);

  always @(posedge clk) begin
    if_a.mem_data <= if_a.mem_addr[11:0];
    if_b.mem_data <= 12'hFFF;
  end

  // Clk edges since reset release, per instance.
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) e_a <= 0;
    else        e_a <= e_a + 1;
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) e_b <= 0;
    else        e_b <= e_b + 1;
  end

  // ---------------- model ----------------
  function automatic exp_t model(geom_t g, int e, logic rn);
    exp_t        x;
    int          n, frame, p, ph, pv;
    logic [16:0] a;
    logic [11:0] d;
    x    = '0;
    x.hs = 1'b1;
    x.vs = 1'b1;
    if (rn !== 1'b1) return x;
    frame = g.h_total * g.v_total;
    n     = e / g.td;
    p     = n % frame;
    x.h   = 10'(p % g.h_total);
    x.v   = 10'(p / g.h_total);
    if (n >= 1) begin
      p      = (n - 1) % frame;
      x.addr = 17'((p % g.h_total) + 640 * (p / g.h_total));
    end
    if (n >= 2) begin
      p  = (n - 2) % frame;
      ph = p % g.h_total;
      pv = p / g.h_total;
      a  = 17'(ph + 640 * pv);
      d  = g.rom_const ? 12'hFFF : a[11:0];
      if (ph < g.h_vis && pv < g.v_vis) x.rgb = ((ph % 16) != 7) ? d : g.bg;
      x.hs = !(ph >= g.hs_lo && ph <= g.hs_hi);
      x.vs = !(pv >= g.vs_lo && pv <= g.vs_hi);
    end
    x.ft = (n > 0) && (e % g.td == 0) && (n % frame == 0);
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    exp_t xa, aa, xb, ab;
    xa = model(ga, e_a, rst_a);
    aa = {if_a.h_cnt, if_a.v_cnt, if_a.mem_addr, ra, ga_o, ba, hs_a, vs_a, ft_a};
    check("model_a", 64'(aa), 64'(xa));
    xb = model(gb, e_b, rst_b);
    ab = {if_b.h_cnt, if_b.v_cnt, if_b.mem_addr, rb, gb_o, bb, hs_b, vs_b, ft_b};
    check("model_b", 64'(ab), 64'(xb));
    if (rst_b === 1'b1 && int'(if_b.v_cnt) > vmax_b) vmax_b = int'(if_b.v_cnt);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pos(input bit sel_b, input int h, input int v, input string name);
    int cnt = 0;
    logic [9:0] ch, cv;
    ch = sel_b ? if_b.h_cnt : if_a.h_cnt;
    cv = sel_b ? if_b.v_cnt : if_a.v_cnt;
    while (cnt < LIMIT && !(int'(ch) == h && int'(cv) == v)) begin
      @(negedge clk);
      cnt++;
      ch = sel_b ? if_b.h_cnt : if_a.h_cnt;
      cv = sel_b ? if_b.v_cnt : if_a.v_cnt;
    end
    check(name, 64'({ch, cv}), 64'({10'(h), 10'(v)}));
  endtask

  task automatic thread_a();
    int cnt;
    repeat (3) @(negedge clk);
    check("a_h_after_3clk", 64'(if_a.h_cnt), 64'(0));
    @(negedge clk);
    check("a_h_after_4clk", 64'(if_a.h_cnt), 64'(1));

    wait_pos(1'b0, 656, 0, "a_reach_656_0");
    cnt = 0;
    while (hs_a !== 1'b0 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    check("a_hsync_delay_clk", 64'(cnt), 64'(8));
    cnt = 0;
    while (hs_a === 1'b0 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    check("a_hsync_width_clk", 64'(cnt), 64'(384));

    wait_pos(1'b0, 799, 0, "a_reach_799_0");
    repeat (TD) @(negedge clk);
    check("a_line_wrap", 64'({if_a.h_cnt, if_a.v_cnt}), 64'({10'd0, 10'd1}));

    wait_pos(1'b0, 9, 1, "a_reach_9_1");
    check("a_bg_pixel_7_1", 64'({ra, ga_o, ba}), 64'(A_BG));
    wait_pos(1'b0, 6, 2, "a_reach_6_2");
    check("a_mem_addr_5_2", 64'(if_a.mem_addr), 64'(1285));
    wait_pos(1'b0, 7, 2, "a_reach_7_2");
    check("a_rgb_5_2", 64'({ra, ga_o, ba}), 64'(12'h505));
    wait_pos(1'b0, 702, 2, "a_reach_702_2");
    check("a_blank_700_2", 64'({ra, ga_o, ba}), 64'(0));
  endtask

  task automatic thread_b();
    int cnt;
    cnt = 0;
    while (ft_b !== 1'b1 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    check("b_first_frame_tick_clk", 64'(cnt), 64'(3120));
    @(negedge clk);
    check("b_frame_tick_width", 64'(ft_b), 64'(0));
    cnt = 1;
    while (ft_b !== 1'b1 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    check("b_frame_spacing_clk", 64'(cnt), 64'(3120));
    check("b_v_max", 64'(vmax_b), 64'(12));

    wait_pos(1'b1, 12, 3, "b_reach_12_3");
    check("b_visible_fff", 64'({rb, gb_o, bb}), 64'(12'hFFF));
    wait_pos(1'b1, 42, 3, "b_reach_42_3");
    check("b_h_porch_blank", 64'({rb, gb_o, bb}), 64'(0));
    wait_pos(1'b1, 12, 7, "b_reach_12_7");
    check("b_v_porch_blank", 64'({rb, gb_o, bb}), 64'(0));

    cnt = 0;
    while (vs_b !== 1'b0 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (vs_b === 1'b0 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    check("b_vsync_width_clk", 64'(cnt), 64'(480));

    wait_pos(1'b1, 30, 4, "b_reach_30_4");
    #2 rst_b = 1'b0;
    #1;
    check("b_midrst_pos", 64'({if_b.h_cnt, if_b.v_cnt}), 64'(0));
    check("b_midrst_rgb", 64'({rb, gb_o, bb}), 64'(0));
    check("b_midrst_sync", 64'({hs_b, vs_b, ft_b}), 64'(3'b110));
    @(negedge clk);
    #2 rst_b = 1'b1;
    cnt = 0;
    while (ft_b !== 1'b1 && cnt < LIMIT) begin @(negedge clk); cnt++; end
    check("b_after_midrst_tick_clk", 64'(cnt), 64'(3120));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (10) @(negedge clk);
    check("a_rst_outputs", 64'({ra, ga_o, ba, hs_a, vs_a, ft_a}), 64'({12'h000, 3'b110}));
    check("a_rst_counters", 64'({if_a.h_cnt, if_a.v_cnt, if_a.mem_addr}), 64'(0));
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      thread_a();
      thread_b();
    join
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
